// File: rtl/axi_req_arbiter.sv
// rtl/axi_req_arbiter.sv - round-robin N:1 AXI request arbiter with independent read/write paths
//
// Shares one AXI master port among NumReq requesters. Reads and writes are
// arbitrated independently, round-robin, one outstanding transaction each.
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous reset, active low
//   slv_req_i   request structs from the requesters
//   slv_resp_o  response structs to the requesters
//   mst_req_o   request struct to the shared master port
//   mst_resp_i  response struct from the shared master port

package ariane_axi;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_req_arbiter #(
    parameter int unsigned NumReq = 2,
    parameter type         req_t  = ariane_axi::req_t,
    parameter type         resp_t = ariane_axi::resp_t
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  req_t  [NumReq-1:0] slv_req_i,
    output resp_t [NumReq-1:0] slv_resp_o,
    output req_t               mst_req_o,
    input  resp_t              mst_resp_i
);
    localparam int unsigned IdxW = $clog2(NumReq);

    typedef logic [IdxW-1:0] idx_t;
    localparam idx_t LastIdx = idx_t'(NumReq - 1);

    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;

    wr_state_e         r_wr_state, w_wr_state_nxt;
    rd_state_e         r_rd_state, w_rd_state_nxt;
    idx_t              r_wgnt, w_wgnt_nxt;
    idx_t              r_rgnt, w_rgnt_nxt;
    idx_t              r_wr_rr, w_wr_rr_nxt;
    idx_t              r_rd_rr, w_rd_rr_nxt;
    logic [NumReq-1:0] w_aw_req;
    logic [NumReq-1:0] w_ar_req;

    function automatic idx_t incr(input idx_t i);
        return (i == LastIdx) ? '0 : i + idx_t'(1);
    endfunction

    // First requesting index starting at the rotation pointer, wrapping modulo NumReq.
    function automatic idx_t rr_pick(input logic [NumReq-1:0] v, input idx_t start);
        idx_t idx;
        idx_t pick;
        logic found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (!found && v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = incr(idx);
        end
        return pick;
    endfunction

    always_comb begin
        w_aw_req = '0;
        w_ar_req = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            w_aw_req[i] = slv_req_i[i].aw_valid;
            w_ar_req[i] = slv_req_i[i].ar_valid;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_rd_state_nxt = r_rd_state;
        w_wgnt_nxt     = r_wgnt;
        w_rgnt_nxt     = r_rgnt;
        w_wr_rr_nxt    = r_wr_rr;
        w_rd_rr_nxt    = r_rd_rr;
        mst_req_o      = '0;
        // Response payloads go to everyone; only the valids are steered by grant.
        for (int i = 0; i < int'(NumReq); i++) begin
            slv_resp_o[i]   = '0;
            slv_resp_o[i].b = mst_resp_i.b;
            slv_resp_o[i].r = mst_resp_i.r;
        end

        case (r_wr_state)
            W_IDLE: begin
                if (|w_aw_req) begin
                    w_wgnt_nxt     = rr_pick(w_aw_req, r_wr_rr);
                    w_wr_state_nxt = W_AW;
                end
            end
            W_AW: begin
                mst_req_o.aw                = slv_req_i[r_wgnt].aw;
                mst_req_o.aw_valid          = slv_req_i[r_wgnt].aw_valid;
                slv_resp_o[r_wgnt].aw_ready = mst_resp_i.aw_ready;
                if (slv_req_i[r_wgnt].aw_valid && mst_resp_i.aw_ready) begin
                    w_wr_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                mst_req_o.w                = slv_req_i[r_wgnt].w;
                mst_req_o.w_valid          = slv_req_i[r_wgnt].w_valid;
                slv_resp_o[r_wgnt].w_ready = mst_resp_i.w_ready;
                if (slv_req_i[r_wgnt].w_valid && mst_resp_i.w_ready && slv_req_i[r_wgnt].w.last) begin
                    w_wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                mst_req_o.b_ready          = slv_req_i[r_wgnt].b_ready;
                slv_resp_o[r_wgnt].b_valid = mst_resp_i.b_valid;
                if (mst_resp_i.b_valid && slv_req_i[r_wgnt].b_ready) begin
                    w_wr_rr_nxt    = incr(r_wgnt);
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase

        case (r_rd_state)
            R_IDLE: begin
                if (|w_ar_req) begin
                    w_rgnt_nxt     = rr_pick(w_ar_req, r_rd_rr);
                    w_rd_state_nxt = R_AR;
                end
            end
            R_AR: begin
                mst_req_o.ar                = slv_req_i[r_rgnt].ar;
                mst_req_o.ar_valid          = slv_req_i[r_rgnt].ar_valid;
                slv_resp_o[r_rgnt].ar_ready = mst_resp_i.ar_ready;
                if (slv_req_i[r_rgnt].ar_valid && mst_resp_i.ar_ready) begin
                    w_rd_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                mst_req_o.r_ready          = slv_req_i[r_rgnt].r_ready;
                slv_resp_o[r_rgnt].r_valid = mst_resp_i.r_valid;
                if (mst_resp_i.r_valid && slv_req_i[r_rgnt].r_ready && mst_resp_i.r.last) begin
                    w_rd_rr_nxt    = incr(r_rgnt);
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_state <= W_IDLE;
            r_rd_state <= R_IDLE;
            r_wgnt     <= '0;
            r_rgnt     <= '0;
            r_wr_rr    <= '0;
            r_rd_rr    <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
            r_wgnt     <= w_wgnt_nxt;
            r_rgnt     <= w_rgnt_nxt;
            r_wr_rr    <= w_wr_rr_nxt;
            r_rd_rr    <= w_rd_rr_nxt;
        end
    end
endmodule

// File: tb/tb_axi_req_arbiter.sv
// tb/tb_axi_req_arbiter.sv - directed self-checking bench for axi_req_arbiter
module tb_axi_req_arbiter;
    logic                    clk;
    logic                    rst_n;
    ariane_axi::req_t  [1:0] slv_req;
    ariane_axi::resp_t [1:0] slv_resp;
    ariane_axi::req_t        mst_req;
    ariane_axi::resp_t       mst_resp;

    int n_vec = 0;
    int n_err = 0;

    axi_req_arbiter #(.NumReq(2)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        slv_req  = '0;
        mst_resp = '0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;

        // Reset with traffic pending on both ports.
        rst_n    = 1'b0;
        slv_req  = '0;
        mst_resp = '0;
        slv_req[0].aw_valid = 1'b1; slv_req[0].aw.id = 4'd1;
        slv_req[0].ar_valid = 1'b1; slv_req[0].ar.id = 4'd1;
        slv_req[1].aw_valid = 1'b1; slv_req[1].aw.id = 4'd2;
        slv_req[1].ar_valid = 1'b1; slv_req[1].ar.id = 4'd2;
        mst_resp.aw_ready = 1'b1; mst_resp.ar_ready = 1'b1; mst_resp.w_ready = 1'b1;
        tick();
        tick();
        chk("rst_mst_aw_valid", 32'(mst_req.aw_valid), 0);
        chk("rst_mst_ar_valid", 32'(mst_req.ar_valid), 0);
        chk("rst_slv0_aw_ready", 32'(slv_resp[0].aw_ready), 0);
        chk("rst_slv1_ar_ready", 32'(slv_resp[1].ar_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_idle_aw_valid", 32'(mst_req.aw_valid), 0);
        tick();
        chk("rel_first_aw_id", 32'(mst_req.aw.id), 1);
        chk("rel_first_ar_id", 32'(mst_req.ar.id), 1);
        chk("rel_slv0_aw_ready", 32'(slv_resp[0].aw_ready), 1);
        chk("rel_slv1_aw_ready", 32'(slv_resp[1].aw_ready), 0);
        do_reset();

        // Single write from port 1, len=3 id=5, W offered before the grant.
        mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
        slv_req[1].aw_valid = 1'b1; slv_req[1].aw.id = 4'd5; slv_req[1].aw.len = 8'd3;
        slv_req[1].w_valid = 1'b1; slv_req[1].w.data = 32'hA0;
        #1;
        chk("wr_idle_aw_valid", 32'(mst_req.aw_valid), 0);
        chk("wr_idle_aw_id_zero", 32'(mst_req.aw.id), 0);
        tick();
        chk("wr_aw_valid", 32'(mst_req.aw_valid), 1);
        chk("wr_aw_id", 32'(mst_req.aw.id), 5);
        chk("wr_aw_len", 32'(mst_req.aw.len), 3);
        chk("wr_slv1_aw_ready", 32'(slv_resp[1].aw_ready), 1);
        chk("wr_early_w_ready", 32'(slv_resp[1].w_ready), 0);
        chk("wr_early_mst_w_valid", 32'(mst_req.w_valid), 0);
        tick();
        slv_req[1].aw_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            slv_req[1].w.data = 32'hA0 + 32'(b);
            slv_req[1].w.last = (b == 3);
            #1;
            chk("wr_w_data", mst_req.w.data, 32'hA0 + 32'(b));
            chk("wr_w_last", 32'(mst_req.w.last), (b == 3) ? 1 : 0);
            chk("wr_slv1_w_ready", 32'(slv_resp[1].w_ready), 1);
            tick();
        end
        slv_req[1].w_valid = 1'b0;
        slv_req[0].b_ready = 1'b1; slv_req[1].b_ready = 1'b1;
        mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd5;
        #1;
        chk("wr_b_valid_owner", 32'(slv_resp[1].b_valid), 1);
        chk("wr_b_valid_other", 32'(slv_resp[0].b_valid), 0);
        chk("wr_b_id_broadcast", 32'(slv_resp[0].b.id), 5);
        chk("wr_mst_b_ready", 32'(mst_req.b_ready), 1);
        tick();
        chk("wr_done_b_valid", 32'(slv_resp[1].b_valid), 0);
        mst_resp.b_valid = 1'b0;

        // Contention: both ports issue single-beat reads back to back.
        mst_resp.ar_ready = 1'b1;
        mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
        slv_req[0].ar_valid = 1'b1; slv_req[0].ar.id = 4'd3; slv_req[0].r_ready = 1'b1;
        slv_req[1].ar_valid = 1'b1; slv_req[1].ar.id = 4'd4; slv_req[1].r_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("rr_ar_id", 32'(mst_req.ar.id), (t % 2 == 0) ? 3 : 4);
            chk("rr_ar_ready_owner", 32'(slv_resp[t % 2].ar_ready), 1);
            chk("rr_ar_ready_other", 32'(slv_resp[1 - t % 2].ar_ready), 0);
            tick();
            chk("rr_r_valid_owner", 32'(slv_resp[t % 2].r_valid), 1);
            chk("rr_r_valid_other", 32'(slv_resp[1 - t % 2].r_valid), 0);
            tick();
            chk("rr_idle_ar_valid", 32'(mst_req.ar_valid), 0);
        end
        slv_req[0].ar_valid = 1'b0; slv_req[1].ar_valid = 1'b0;
        mst_resp.r_valid = 1'b0; mst_resp.r.last = 1'b0;

        // Concurrency: port 0 writes 8 beats while port 1 reads 3 beats.
        mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
        slv_req[0].aw_valid = 1'b1; slv_req[0].aw.id = 4'd7; slv_req[0].aw.len = 8'd7;
        slv_req[0].w_valid = 1'b1;
        slv_req[1].ar_valid = 1'b1; slv_req[1].ar.id = 4'd9; slv_req[1].ar.len = 8'd2;
        tick();
        chk("cc_aw_id", 32'(mst_req.aw.id), 7);
        chk("cc_ar_id", 32'(mst_req.ar.id), 9);
        tick();
        slv_req[0].aw_valid = 1'b0; slv_req[1].ar_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            slv_req[0].w.data = 32'h10 + 32'(k);
            slv_req[0].w.last = (k == 7);
            mst_resp.r_valid = (k < 3);
            mst_resp.r.data = 32'h20 + 32'(k);
            mst_resp.r.last = (k == 2);
            #1;
            chk("cc_w_data", mst_req.w.data, 32'h10 + 32'(k));
            chk("cc_slv0_w_ready", 32'(slv_resp[0].w_ready), 1);
            if (k < 3) begin
                chk("cc_r_valid_owner", 32'(slv_resp[1].r_valid), 1);
                chk("cc_r_valid_other", 32'(slv_resp[0].r_valid), 0);
            end else begin
                chk("cc_rd_done_r_ready", 32'(mst_req.r_ready), 0);
            end
            tick();
        end
        slv_req[0].w_valid = 1'b0;
        mst_resp.r_valid = 1'b0;
        mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd7;
        #1;
        chk("cc_b_valid_owner", 32'(slv_resp[0].b_valid), 1);
        chk("cc_b_valid_other", 32'(slv_resp[1].b_valid), 0);
        tick();
        mst_resp.b_valid = 1'b0;

        // Backpressure: AW stalled 5 cycles, then B held off by the requester for 3.
        mst_resp.aw_ready = 1'b0;
        slv_req[1].aw_valid = 1'b1; slv_req[1].aw.id = 4'd3; slv_req[1].aw.len = 8'd1;
        slv_req[1].w_valid = 1'b1; slv_req[1].w.last = 1'b0; slv_req[1].w.data = 32'h30;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_aw_held", 32'(mst_req.aw_valid), 1);
            chk("bp_w_waits", 32'(mst_req.w_valid), 0);
            tick();
        end
        mst_resp.aw_ready = 1'b1;
        #1;
        chk("bp_aw_ready", 32'(slv_resp[1].aw_ready), 1);
        tick();
        slv_req[1].aw_valid = 1'b0;
        #1;
        chk("bp_w0_data", mst_req.w.data, 32'h30);
        tick();
        slv_req[1].w.data = 32'h31; slv_req[1].w.last = 1'b1;
        #1;
        chk("bp_w1_data", mst_req.w.data, 32'h31);
        tick();
        slv_req[1].w_valid = 1'b0;
        slv_req[1].b_ready = 1'b0;
        mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_b_valid_held", 32'(slv_resp[1].b_valid), 1);
            chk("bp_mst_b_ready_low", 32'(mst_req.b_ready), 0);
            tick();
        end
        slv_req[1].b_ready = 1'b1;
        #1;
        chk("bp_mst_b_ready", 32'(mst_req.b_ready), 1);
        tick();
        chk("bp_b_done", 32'(slv_resp[1].b_valid), 0);
        mst_resp.b_valid = 1'b0;

        // Read with r_valid toggling: exactly four beats to port 0.
        slv_req[0].ar_valid = 1'b1; slv_req[0].ar.id = 4'd2; slv_req[0].ar.len = 8'd3;
        tick();
        tick();
        slv_req[0].ar_valid = 1'b0;
        beats = 0;
        for (int c = 0; c < 7; c++) begin
            mst_resp.r_valid = (c % 2 == 0);
            mst_resp.r.last = (c == 6);
            #1;
            chk("bp_r_valid", 32'(slv_resp[0].r_valid), (c % 2 == 0) ? 1 : 0);
            chk("bp_r_valid_other", 32'(slv_resp[1].r_valid), 0);
            if (slv_resp[0].r_valid && slv_req[0].r_ready) beats++;
            tick();
        end
        mst_resp.r_valid = 1'b0; mst_resp.r.last = 1'b0;
        chk("bp_r_beats", 32'(beats), 4);
        chk("bp_rd_idle_r_ready", 32'(mst_req.r_ready), 0);

        // Reset during W beat 2 of 4, then a single-beat write.
        slv_req[0].aw_valid = 1'b1; slv_req[0].aw.id = 4'd6; slv_req[0].aw.len = 8'd3;
        slv_req[0].w_valid = 1'b1; slv_req[0].w.last = 1'b0;
        tick();
        tick();
        slv_req[0].aw_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("mr_w_valid_before", 32'(mst_req.w_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mr_w_valid_reset", 32'(mst_req.w_valid), 0);
        chk("mr_w_ready_reset", 32'(slv_resp[0].w_ready), 0);
        do_reset();
        mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
        slv_req[1].aw_valid = 1'b1; slv_req[1].aw.id = 4'd8; slv_req[1].aw.len = 8'd0;
        tick();
        chk("mr_aw_id", 32'(mst_req.aw.id), 8);
        tick();
        slv_req[1].aw_valid = 1'b0;
        slv_req[1].w_valid = 1'b1; slv_req[1].w.last = 1'b1; slv_req[1].w.data = 32'h55;
        #1;
        chk("mr_w_last", 32'(mst_req.w.last), 1);
        chk("mr_w_ready", 32'(slv_resp[1].w_ready), 1);
        tick();
        chk("mr_resp_w_valid", 32'(mst_req.w_valid), 0);
        slv_req[1].w_valid = 1'b0;
        slv_req[1].b_ready = 1'b1;
        mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd8;
        #1;
        chk("mr_b_valid", 32'(slv_resp[1].b_valid), 1);
        chk("mr_b_id", 32'(slv_resp[1].b.id), 8);
        tick();
        chk("mr_b_done", 32'(slv_resp[1].b_valid), 0);
        mst_resp.b_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
